// File: rtl/branch_resolver_pkg.sv
// Shared pipeline definitions: control-class encoding and the shadow-entry record
// used by the branch predictor and the pipeline top.
package branch_resolver_pkg;

  localparam logic [31:0] INSN_BYTES = 32'd4;

  typedef enum logic [1:0] {
    CTRL_NONE   = 2'd0,
    CTRL_BRANCH = 2'd1,
    CTRL_JUMP   = 2'd2,
    CTRL_JR     = 2'd3
  } ctrl_class_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;
  } shadow_entry_t;

  // EX-stage class flags are mutually exclusive, so a priority encode is exact.
  function automatic ctrl_class_e ctrl_class(input logic is_branch, input logic is_jump,
                                             input logic is_jr);
    if (is_branch)    return CTRL_BRANCH;
    else if (is_jump) return CTRL_JUMP;
    else if (is_jr)   return CTRL_JR;
    else              return CTRL_NONE;
  endfunction

  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    return pc + INSN_BYTES;
  endfunction

endpackage

// File: rtl/bp_shadow_stage.sv
// One shadow-pipeline entry: reset and kill clear it, load captures the upstream entry.
module bp_shadow_stage
  import branch_resolver_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          kill,
  input  shadow_entry_t in_entry,
  output shadow_entry_t entry
);

  always_ff @(posedge clk) begin
    if (rst) begin
      entry <= '0;
    end else if (kill) begin
      entry.valid <= 1'b0;
    end else if (load) begin
      entry <= in_entry;
    end
  end

endmodule

// File: rtl/branch_resolver.sv
// Resolves EX-stage control flow against the prediction carried alongside it,
// redirects fetch on a mispredict, trains the predictor and counts events.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic [31:0]      if_pc,
  input  logic             if_pred_taken,
  input  logic [31:0]      if_pred_target,
  input  logic             stall,
  input  logic             ex_is_branch,
  input  logic             ex_is_jump,
  input  logic             ex_is_jr,
  input  logic             ex_taken,
  input  logic [31:0]      ex_target,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic             flush,
  output logic             update_en,
  output logic [31:0]      update_pc,
  output logic             update_taken,
  output logic [31:0]      update_target,
  output logic             update_is_branch,
  output logic [CNT_W-1:0] perf_branches,
  output logic [CNT_W-1:0] perf_mispredicts
);

  shadow_entry_t if_entry, d_entry, e_entry;
  ctrl_class_e   cls;
  logic          resolve, actual_taken, mispredict, train, any_ctrl;
  logic [31:0]   actual_next;

  assign if_entry = '{valid: if_valid, pc: if_pc, pred_taken: if_pred_taken,
                      pred_target: if_pred_target};

  bp_shadow_stage u_d_stage (
    .clk      (clk),
    .rst      (rst),
    .load     (!stall),
    .kill     (redirect),
    .in_entry (if_entry),
    .entry    (d_entry)
  );

  bp_shadow_stage u_e_stage (
    .clk      (clk),
    .rst      (rst),
    .load     (!stall),
    .kill     (redirect),
    .in_entry (d_entry),
    .entry    (e_entry)
  );

  always_comb begin
    cls          = ctrl_class(ex_is_branch, ex_is_jump, ex_is_jr);
    resolve      = e_entry.valid && !stall;
    any_ctrl     = (cls != CTRL_NONE);
    actual_taken = (cls == CTRL_JUMP) || (cls == CTRL_JR) || ((cls == CTRL_BRANCH) && ex_taken);
    actual_next  = actual_taken ? ex_target : seq_pc(e_entry.pc);
    // A non-control instruction predicted taken also counts as a mispredict.
    mispredict   = (actual_taken != e_entry.pred_taken) ||
                   (actual_taken && (e_entry.pred_target != ex_target));
    // Register-indirect targets are not trained into the predictor.
    train        = resolve && ((cls == CTRL_BRANCH) || (cls == CTRL_JUMP));
    redirect     = resolve && mispredict;
    flush        = redirect;
    redirect_pc  = redirect ? actual_next : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      update_en        <= 1'b0;
      update_pc        <= '0;
      update_taken     <= 1'b0;
      update_target    <= '0;
      update_is_branch <= 1'b0;
    end else begin
      update_en <= train;
      if (train) begin
        update_pc        <= e_entry.pc;
        update_taken     <= actual_taken;
        update_target    <= ex_target;
        update_is_branch <= (cls == CTRL_BRANCH);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else begin
      if (resolve && any_ctrl && (perf_branches != '1)) begin
        perf_branches <= perf_branches + 1'b1;
      end
      if (redirect && (perf_mispredicts != '1)) begin
        perf_mispredicts <= perf_mispredicts + 1'b1;
      end
    end
  end

endmodule
